receive: RTL and testbench

- Receives a framed block of 16-bit words from L'Imperatrice via the UART receiver and writes them into SRAM at consecutive even addresses.
- Used to download feature vectors and parameters before scoring. It is the inbound counterpart of the senone-score sender.
- Shares the SRAM bus with other masters, so it drives its bus signals only while writing and is high-impedance otherwise.
- Frame format: count word N, then N data words, then one checksum word.

---
 rtl/receive.sv | 155 +++++++++++++++
 tb/tb_receive.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/receive.sv
// receive: inbound frame loader. Takes 16-bit words from the UART receiver,
// parses a frame (count N, N data words, checksum), and writes the data words
// to SRAM at consecutive even addresses starting at base_addr.
//
// The SRAM bus is shared with other masters. This block drives data_out,
// data_addr and write_data only while a write is in progress. At all other
// times these outputs are high-impedance.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   start_recv    one-cycle pulse that arms reception (honoured only in IDLE)
//   rx_value      received word, qualified by rx_valid
//   rx_valid      one-cycle pulse per received word
//   sram_ready    write-complete from SRAM, sampled while writing
//   data_out      SRAM write data   (Z unless writing)
//   data_addr     SRAM word address (Z unless writing)
//   write_data    SRAM write strobe (Z unless writing)
//   word_count    data words written in the current frame
//   recv_done     one-cycle pulse: frame stored and checksum matched
//   recv_error    one-cycle pulse: bad count, overrun or checksum mismatch
module receive #(
  parameter int          max_words = 255,
  parameter logic [20:0] base_addr = 21'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_recv,
  input  logic [15:0] rx_value,
  input  logic        rx_valid,
  input  logic        sram_ready,
  output logic [15:0] data_out,
  output logic [20:0] data_addr,
  output logic        write_data,
  output logic [7:0]  word_count,
  output logic        recv_done,
  output logic        recv_error
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_COUNT = 3'd1;
  localparam logic [2:0] WAIT_DATA  = 3'd2;
  localparam logic [2:0] WRITING    = 3'd3;
  localparam logic [2:0] WAIT_CHECK = 3'd4;

  localparam logic [15:0] MAX_N = 16'(max_words);

  logic [2:0]  state;
  logic        pend_valid;
  logic [15:0] pend_value;
  logic [7:0]  index;
  logic [7:0]  n_words;
  logic [15:0] sum;
  logic [15:0] wr_value;
  logic        waiting;
  logic        consume;
  logic        overrun;
  logic        bad_count;
  logic        last_word;
  logic [20:0] wr_addr;

  // Every WAIT state consumes the pending word in the cycle it is seen.
  // So pend can only be stuck full while WRITING, and that is the one
  // place where an overrun can occur.
  assign waiting   = (state == WAIT_COUNT) || (state == WAIT_DATA) ||
                     (state == WAIT_CHECK);
  assign consume   = waiting && pend_valid;
  assign overrun   = (state != IDLE) && rx_valid && pend_valid && !consume;
  assign bad_count = (pend_value == 16'd0) || (pend_value > MAX_N);
  assign last_word = (index == n_words - 8'd1);
  assign wr_addr   = base_addr + {12'd0, index, 1'b0};

  // The shared bus is released whenever this block is not writing.
  assign data_out   = (state == WRITING) ? wr_value : 16'bz;
  assign data_addr  = (state == WRITING) ? wr_addr  : 21'bz;
  assign write_data = (state == WRITING) ? 1'b1     : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_value <= 16'd0;
      index      <= 8'd0;
      n_words    <= 8'd0;
      sum        <= 16'd0;
      wr_value   <= 16'd0;
      word_count <= 8'd0;
      recv_done  <= 1'b0;
      recv_error <= 1'b0;
    end else begin
      recv_done  <= 1'b0;
      recv_error <= 1'b0;

      // Holding register. A new word that arrives in the same cycle as a
      // consume replaces the consumed word, so pend stays full.
      if ((state != IDLE) && rx_valid) begin
        pend_value <= rx_value;
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end

      if (overrun) begin
        recv_error <= 1'b1;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_recv) begin
              state      <= WAIT_COUNT;
              index      <= 8'd0;
              sum        <= 16'd0;
              word_count <= 8'd0;
              pend_valid <= 1'b0;
            end
          end
          WAIT_COUNT: begin
            if (pend_valid) begin
              if (bad_count) begin
                recv_error <= 1'b1;
                state      <= IDLE;
              end else begin
                n_words <= pend_value[7:0];
                sum     <= pend_value;
                state   <= WAIT_DATA;
              end
            end
          end
          WAIT_DATA: begin
            if (pend_valid) begin
              wr_value <= pend_value;
              sum      <= sum + pend_value;
              state    <= WRITING;
            end
          end
          WRITING: begin
            if (sram_ready) begin
              index      <= index + 8'd1;
              word_count <= index + 8'd1;
              state      <= last_word ? WAIT_CHECK : WAIT_DATA;
            end
          end
          WAIT_CHECK: begin
            if (pend_valid) begin
              if (pend_value == sum) recv_done  <= 1'b1;
              else                   recv_error <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receive.sv
// Directed bench for receive. A negedge monitor logs completed SRAM writes and
// done/error pulses. A ready driver models three SRAM behaviours: always
// ready, never ready, and ready after 4 strobe cycles.
module tb_receive;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_recv;
  logic [15:0] rx_value;
  logic        rx_valid;
  logic        sram_ready;
  logic [15:0] data_out;
  logic [20:0] data_addr;
  logic        write_data;
  logic [7:0]  word_count;
  logic        recv_done;
  logic        recv_error;

  receive dut (
    .clk        (clk),
    .reset      (reset),
    .start_recv (start_recv),
    .rx_value   (rx_value),
    .rx_valid   (rx_valid),
    .sram_ready (sram_ready),
    .data_out   (data_out),
    .data_addr  (data_addr),
    .write_data (write_data),
    .word_count (word_count),
    .recv_done  (recv_done),
    .recv_error (recv_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // ready_mode: 0 = always ready, 1 = never ready, 2 = ready after 4 strobe cycles
  int ready_mode = 0;
  int wcyc = 0;
  always @(posedge clk) begin
    #2;
    if (ready_mode == 0) sram_ready = 1'b1;
    else if (ready_mode == 1) sram_ready = 1'b0;
    else begin
      if (write_data === 1'b1) wcyc++;
      else wcyc = 0;
      sram_ready = (wcyc >= 4);
    end
  end

  logic [20:0] wa_q[$];
  logic [15:0] wd_q[$];
  int hi_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, unstable = 0;
  logic        prev_hi = 1'b0, prev_rdy = 1'b0;
  logic [15:0] prev_d = '0;
  logic [20:0] prev_a = '0;

  always @(negedge clk) begin
    if (write_data === 1'b1) begin
      hi_cnt++;
      if (prev_hi && !prev_rdy && (data_out !== prev_d || data_addr !== prev_a)) unstable++;
      if (sram_ready === 1'b1) begin
        wa_q.push_back(data_addr);
        wd_q.push_back(data_out);
      end
    end
    if (recv_done === 1'b1) done_cnt++;
    if (recv_error === 1'b1) err_cnt++;
    if (recv_done === 1'b1 && recv_error === 1'b1) both_cnt++;
    prev_hi  = (write_data === 1'b1);
    prev_rdy = (sram_ready === 1'b1);
    prev_d   = data_out;
    prev_a   = data_addr;
  end

  // The main flow always sits 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    hi_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; unstable = 0;
  endtask

  task automatic arm();
    start_recv = 1'b1;
    tick(1);
    start_recv = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    rx_value = v;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic chk_writes(input string tag, input int n,
                            input logic [20:0] a0, input logic [15:0] d0,
                            input logic [20:0] a1, input logic [15:0] d1,
                            input logic [20:0] a2, input logic [15:0] d2);
    logic [20:0] ea[3];
    logic [15:0] ed[3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    chk({tag, " nwrites"}, wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk($sformatf("%s addr%0d", tag, i), wa_q[i], ea[i]);
      chk($sformatf("%s data%0d", tag, i), wd_q[i], ed[i]);
    end
  endtask

  logic [15:0] frame1[5];

  initial begin
    frame1[0] = 16'd3;      frame1[1] = 16'h0001; frame1[2] = 16'hFFFF;
    frame1[3] = 16'h1234;   frame1[4] = 16'h1237;
    reset = 1'b1; start_recv = 1'b0; rx_value = '0; rx_valid = 1'b0; sram_ready = 1'b0;
    tick(3);
    chk("rst strobe", {31'd0, write_data === 1'b1}, 0);
    chk("rst word_count", word_count, 0);
    chk("rst done", recv_done, 0);
    chk("rst error", recv_error, 0);
    reset = 1'b0;
    tick(2);

    // Frame 1: SRAM always ready.
    clr();
    arm();
    for (int i = 0; i < 5; i++) begin
      send(frame1[i]);
      tick(3);
    end
    tick(2);
    chk_writes("f1", 3, 21'd0, 16'h0001, 21'd2, 16'hFFFF, 21'd4, 16'h1234);
    chk("f1 word_count", word_count, 3);
    chk("f1 done", done_cnt, 1);
    chk("f1 error", err_cnt, 0);

    // Frame 1 again: slow SRAM, widely spaced words.
    clr();
    ready_mode = 2;
    tick(1);
    arm();
    for (int i = 0; i < 5; i++) begin
      send(frame1[i]);
      tick(20);
      if (i == 2) chk("f2 gap strobe", {31'd0, write_data === 1'b1}, 0);
    end
    chk_writes("f2", 3, 21'd0, 16'h0001, 21'd2, 16'hFFFF, 21'd4, 16'h1234);
    chk("f2 strobe cycles", hi_cnt, 12);
    chk("f2 stable", unstable, 0);
    chk("f2 done", done_cnt, 1);
    chk("f2 error", err_cnt, 0);
    ready_mode = 0;
    tick(1);

    // Bad counts: 0 and 256.
    clr();
    arm();
    send(16'd0);
    tick(3);
    chk("cnt0 error", err_cnt, 1);
    arm();
    send(16'd256);
    tick(3);
    chk("cnt256 error", err_cnt, 2);
    chk("badcnt strobe", hi_cnt, 0);
    chk("badcnt done", done_cnt, 0);
    // The block must be back in IDLE and able to take a fresh frame.
    arm();
    send(16'd1); tick(2); send(16'h0042); tick(2); send(16'h0043); tick(3);
    chk("badcnt recover done", done_cnt, 1);

    // Bad checksum.
    clr();
    arm();
    send(16'd2); tick(2);
    send(16'd5); tick(2);
    send(16'd6); tick(2);
    send(16'h0000); tick(3);
    chk_writes("cks", 2, 21'd0, 16'd5, 21'd2, 16'd6, 21'd0, 16'd0);
    chk("cks error", err_cnt, 1);
    chk("cks done", done_cnt, 0);

    // Overrun: SRAM stalled while three words arrive back to back.
    clr();
    ready_mode = 1;
    tick(1);
    arm();
    send(16'd4); tick(2);
    send(16'd10); send(16'd11); send(16'd12);
    tick(3);
    chk("ovr error", err_cnt, 1);
    chk("ovr done", done_cnt, 0);
    chk("ovr writes", wa_q.size(), 0);
    chk("ovr strobe cycles", hi_cnt, 1);
    chk("ovr bus released", {31'd0, write_data === 1'b1}, 0);

    // Reset during the second write, then a fresh frame.
    clr();
    ready_mode = 0;
    tick(1);
    arm();
    send(16'd3); tick(2);
    send(16'h0011); tick(2);
    ready_mode = 1;
    tick(1);
    send(16'h0022); tick(2);
    chk("mid strobe", {31'd0, write_data === 1'b1}, 1);
    chk("mid data", data_out, 16'h0022);
    chk("mid addr", data_addr, 21'd2);
    chk("mid word_count", word_count, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst strobe", {31'd0, write_data === 1'b1}, 0);
    chk("arst word_count", word_count, 0);
    chk("arst done", recv_done, 0);
    chk("arst error", recv_error, 0);
    tick(2);
    reset = 1'b0;
    ready_mode = 0;
    tick(2);
    clr();
    arm();
    send(16'd1); tick(2);
    send(16'd7); tick(2);
    send(16'd8); tick(3);
    chk_writes("post", 1, 21'd0, 16'd7, 21'd0, 16'd0, 21'd0, 16'd0);
    chk("post done", done_cnt, 1);
    chk("post error", err_cnt, 0);
    chk("post word_count", word_count, 1);
    chk("never both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
